// File: rtl/elastic_pipe_reg.sv
// Elastic pipeline register: STAGES chained stages, each a main register plus a
// one-entry skid buffer, so every ready signal comes straight from a flop.
module elastic_pipe_reg #(
  parameter int WIDTH          = 8,
  parameter int STAGES         = 2,
  parameter bit CLEAR_ON_FLUSH = 1'b1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic                             in_valid,
  input  logic [WIDTH-1:0]                 in_data,
  output logic                             in_ready,
  output logic                             out_valid,
  output logic [WIDTH-1:0]                 out_data,
  input  logic                             out_ready,
  output logic [$clog2(2*STAGES+1)-1:0]    count
);

  localparam int CW = $clog2(2*STAGES+1);

  logic [STAGES-1:0] stage_valid;
  logic [STAGES-1:0] stage_ready;
  logic [WIDTH-1:0]  stage_data [STAGES];

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic             main_v_reg;
      logic             skid_v_reg;
      logic [WIDTH-1:0] main_d_reg;
      logic [WIDTH-1:0] skid_d_reg;
      logic             up_valid;
      logic [WIDTH-1:0] up_data;
      logic             dn_ready;
      logic             accept;
      logic             drain;

      if (gi == 0) begin : g_head
        assign up_valid = in_valid;
        assign up_data  = in_data;
      end else begin : g_link
        assign up_valid = stage_valid[gi-1];
        assign up_data  = stage_data[gi-1];
      end

      if (gi == STAGES-1) begin : g_tail
        assign dn_ready = out_ready;
      end else begin : g_next
        assign dn_ready = stage_ready[gi+1];
      end

      assign accept = up_valid & ~skid_v_reg;
      assign drain  = ~main_v_reg | dn_ready;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          main_v_reg <= 1'b0;
          skid_v_reg <= 1'b0;
          main_d_reg <= '0;
          skid_d_reg <= '0;
        end else if (flush) begin
          main_v_reg <= 1'b0;
          skid_v_reg <= 1'b0;
          if (CLEAR_ON_FLUSH) begin
            main_d_reg <= '0;
            skid_d_reg <= '0;
          end
        end else if (drain) begin
          // A parked skid entry is older than anything upstream, so it goes first.
          if (skid_v_reg) begin
            main_v_reg <= 1'b1;
            main_d_reg <= skid_d_reg;
            skid_v_reg <= 1'b0;
          end else begin
            main_v_reg <= accept;
            if (accept) begin
              main_d_reg <= up_data;
            end
          end
        end else if (accept) begin
          skid_v_reg <= 1'b1;
          skid_d_reg <= up_data;
        end
      end

      assign stage_valid[gi] = main_v_reg;
      assign stage_ready[gi] = ~skid_v_reg;
      assign stage_data[gi]  = main_d_reg;
    end
  endgenerate

  assign in_ready  = stage_ready[0];
  assign out_valid = stage_valid[STAGES-1];
  assign out_data  = stage_data[STAGES-1];

  logic          in_hs;
  logic          out_hs;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

  always_comb begin
    count_next = count_reg;
    case ({in_hs, out_hs})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (flush) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: doc/elastic_pipe_reg.md
# elastic_pipe_reg

Parametrised elastic pipeline register: a chain of `STAGES` registered stages, each with a main register and a one-entry skid buffer, moving `WIDTH`-bit payloads under a valid/ready handshake. It extends the plain enable-gated pipeline flop with per-stage backpressure, synchronous flush, and an occupancy count. The processor datapath uses it between pipeline stages (e.g. fetch→decode, execute→memory) and on any path that needs decoupling from downstream stalls.

## Interface
- `WIDTH`, 8: payload width in bits (≥1).
- `STAGES`, 2: number of register stages (1..8).
- `CLEAR_ON_FLUSH`, 1: 1 = flush also zeroes all data registers; 0 = only valid bits are cleared.
- `clk` input 1: clock, rising edge.
- `reset` input 1: reset, asynchronous, active-high.
- `flush` input 1: synchronous clear of all stored entries.
- `in_valid` input 1: upstream has a payload.
- `in_data` input WIDTH: upstream payload.
- `in_ready` output 1: stage 0 can accept a payload.
- `out_valid` output 1: last stage holds a payload.
- `out_data` output WIDTH: last-stage payload.
- `out_ready` input 1: downstream accepts a payload.
- `count` output $clog2(2*STAGES+1): number of valid entries held (main + skid, all stages).

## Operation
- Stage i: upstream is `in_*` for i=0, otherwise stage i-1 outputs. Downstream is `out_ready` for the last stage, otherwise stage i+1 ready.
- Stage state: `main_v`, `main_d`, `skid_v`, `skid_d`. Stage ready = `!skid_v`, driven directly from the register with no combinational path from downstream ready. Stage valid/data = `main_v`/`main_d`.
- `accept` = upstream valid & stage ready. `drain` = `!main_v` | downstream ready.
- If `drain`:
  - when `skid_v`=1: `main` loads the skid contents and `skid_v` clears.
  - otherwise: `main` loads the upstream payload if `accept`, else `main_v` goes to 0.
- If not `drain`: `main` holds; on `accept`, the skid loads the upstream payload and `skid_v` goes to 1.
- A handshake occurs on any cycle where valid & ready are both high. Payloads are never dropped, duplicated, or reordered except by flush.
- `flush` (priority below reset, above everything else):
  - all `main_v`/`skid_v` clear at the next edge;
  - data registers clear if `CLEAR_ON_FLUSH`=1;
  - an input handshake in the flush cycle is discarded;
  - an output handshake in the flush cycle still counts as consumed downstream.
- `count` is registered: +1 per input handshake, −1 per output handshake, net 0 when both occur; forced to 0 on flush/reset. It never exceeds 2*STAGES.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `in_ready`=1, `count`=0, all internal valid and data registers 0.
- Latency: with no backpressure, an input handshake at edge N gives `out_valid`=1 after edge N+STAGES-1. Stage 0 captures at edge N; each further stage adds 1 cycle.
- Throughput: 1 payload/cycle sustained while `out_ready`=1.
- Backpressure: after `out_ready` falls, the pipe absorbs up to 2*STAGES payloads in total. `in_ready` falls the cycle after stage 0's skid fills. Ready propagates backward one stage per cycle.
- Resume: one cycle after `out_ready` rises, the skid-held payload is presented; no bubble is inserted.
- Full: `count`=2*STAGES; `in_ready`=0 and no upstream accept occurs.
- Empty: `count`=0 and `out_valid`=0. `out_data` then holds its stale value (or 0 after a flush with `CLEAR_ON_FLUSH`=1).
- Reset mid-transfer: asynchronous; all outputs return to their reset values immediately, without waiting for a clock edge.

## Test plan
- Reset/idle (WIDTH=8, STAGES=2): assert `reset` mid-cycle -> `out_valid`=0, `out_data`=0x00, `in_ready`=1, `count`=0, all without a clock edge.
- Streaming (`out_ready`=1): inputs 0x01..0x10 on consecutive cycles -> same sequence on `out_data`, first word one cycle after its capture (STAGES=2), no gaps, `count` steady at 2.
- Fill (`out_ready`=0): offer 0xA0..0xA7 continuously -> exactly 4 accepted (0xA0..0xA3), `in_ready`=0 thereafter, `count`=4. Then `out_ready`=1 -> 0xA0..0xA3 output in order, then 0xA4 onward.
- Random backpressure: 1000 random payloads with random `in_valid`/`out_ready` -> scoreboard shows an in-order, lossless match and `count` equals the model occupancy every cycle.
- Flush: pipe holds 0x11,0x22,0x33; assert `flush` with `in_valid`=1 and `in_data`=0x44 -> next cycle `out_valid`=0, `count`=0, data regs 0 (`CLEAR_ON_FLUSH`=1), 0x44 never appears at the output.
- Simultaneous in/out at full (STAGES=1, `count`=2): `out_ready`=1 while `in_valid`=1 -> one output; `in_ready` returns to 1 the following cycle; `count` goes 2→1.
